shift_add_mult_ctrl: RTL and testbench

//   FSM controller that sequences an N-bit shift-and-add multiplier datapath built from

---
 rtl/shift_add_mult_ctrl.sv | 125 ++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for an N-bit shift-and-add multiplier datapath.
// Sequences the M/Q/A register strobes and the start/busy/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  multiply request, sampled only in IDLE
//   q0     LSB of the datapath Q register
//   m_en   load multiplicand into M
//   q_ld   parallel load of multiplier into Q
//   a_en   A register enable (add M, or clear when a_izR)
//   a_izR  A register synchronous clear, qualified by a_en
//   sh_en  shift {carry,A,Q} right by one
//   busy   high from INIT through DONE
//   done   one-cycle pulse, product valid in {A,Q}
module shift_add_mult_ctrl #(
    parameter  int N     = 8,
    localparam int CNT_W = $clog2(N) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    output logic m_en,
    output logic q_ld,
    output logic a_en,
    output logic a_izR,
    output logic sh_en,
    output logic busy,
    output logic done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

    // The exit at N-1 happens before the counter could ever wrap.
    assign last_iter = (cnt == LAST);

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = start ? S_INIT : S_IDLE;
            S_INIT:  state_nx = S_CALC;
            S_CALC:  state_nx = S_SHIFT;
            S_SHIFT: state_nx = last_iter ? S_DONE : S_CALC;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_INIT) begin
            cnt <= '0;
        end else if (state == S_SHIFT) begin
            cnt <= cnt + ONE;
        end
    end

    // Strobes are decoded from state only, except the CALC add
    // which follows q0 combinationally so no extra cycle is spent.
    always_comb begin
        m_en  = 1'b0;
        q_ld  = 1'b0;
        a_en  = 1'b0;
        a_izR = 1'b0;
        sh_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_INIT: begin
                m_en  = 1'b1;
                q_ld  = 1'b1;
                a_en  = 1'b1;
                a_izR = 1'b1;
                busy  = 1'b1;
            end
            S_CALC: begin
                a_en = q0;
                busy = 1'b1;
            end
            S_SHIFT: begin
                sh_en = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    a_mutex_a_sh : assert property (
        @(posedge clk) disable iff (rst) !(a_en && sh_en));
    a_mutex_q_sh : assert property (
        @(posedge clk) disable iff (rst) !(q_ld && sh_en));
    a_done_pulse : assert property (
        @(posedge clk) disable iff (rst) done |=> !done);
    a_busy_state : assert property (
        @(posedge clk) disable iff (rst) busy == (state != S_IDLE));
`endif

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Testbench for shift_add_mult_ctrl with a bench-side datapath.
// Products and timing are checked against plain arithmetic.
module tb_shift_add_mult_ctrl;

    localparam int N = 8;

    logic clk;
    logic rst;
    logic start;
    logic q0;
    logic m_en;
    logic q_ld;
    logic a_en;
    logic a_izR;
    logic sh_en;
    logic busy;
    logic done;

    logic [7:0] mcand;
    logic [7:0] mplier;
    logic [7:0] m_r;
    logic [7:0] q_r;
    logic [7:0] a_r;
    logic       c_r;

    int n_vec;
    int n_err;
    logic prev_done;

    shift_add_mult_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q0    (q0),
        .m_en  (m_en),
        .q_ld  (q_ld),
        .a_en  (a_en),
        .a_izR (a_izR),
        .sh_en (sh_en),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign q0 = q_r[0];

    // Datapath the controller drives: M, Q, A plus adder carry.
    initial begin
        m_r = '0;
        q_r = '0;
        a_r = '0;
        c_r = 1'b0;
    end

    always @(posedge clk) begin
        if (m_en) m_r <= mcand;
        if (q_ld) q_r <= mplier;
        if (a_en) begin
            if (a_izR) {c_r, a_r} <= 9'd0;
            else       {c_r, a_r} <= {1'b0, a_r} + {1'b0, m_r};
        end
        if (sh_en) {c_r, a_r, q_r} <= {1'b0, c_r, a_r, q_r[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle protocol checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (sh_en) check("mutex", {30'd0, a_en, q_ld}, 32'd0);
            if (prev_done) check("done_pulse", {31'd0, done}, 32'd0);
        end
        prev_done <= done & ~rst;
    end

    function automatic logic [6:0] outs();
        return {m_en, q_ld, a_en, a_izR, sh_en, busy, done};
    endfunction

    task automatic run_mult(input logic [7:0] m, input logic [7:0] q,
                            input bit pulse, input string tag);
        int cyc;
        int dcyc;
        int shc;
        int dones;
        logic [15:0] prod;
        logic [7:0]  amask;
        dcyc  = 0;
        shc   = 0;
        dones = 0;
        amask = '0;
        prod  = '0;
        @(negedge clk);
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 60 && (dcyc == 0 || cyc <= dcyc + 3)) begin
            if (a_en && !m_en && shc < 8) amask[shc] = 1'b1;
            if (sh_en) shc++;
            if (done) begin
                dones++;
                if (dcyc == 0) begin
                    dcyc = cyc;
                    prod = {a_r, q_r};
                end
            end
            if (pulse) start = (cyc == 3 || cyc == 6 || cyc == 11);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, ".done_cyc"}, dcyc, 2 * N + 2);
        check({tag, ".shifts"}, shc, N);
        check({tag, ".add_iters"}, {24'd0, amask}, {24'd0, q});
        check({tag, ".product"}, {16'd0, prod}, int'(m) * int'(q));
        check({tag, ".done_cnt"}, dones, 1);
        check({tag, ".idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int d1;
        int d2;
        int init2;
        int idle_cnt;
        int guard;
        logic [15:0] prod2;
        n_vec     = 0;
        n_err     = 0;
        prev_done = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        #1;
        check("reset_outs", {25'd0, outs()}, 32'd0);
        repeat (2) @(negedge clk);
        check("reset_outs_clk", {25'd0, outs()}, 32'd0);
        rst = 1'b0;

        run_mult(8'd13, 8'd11, 1'b0, "m13q11");
        run_mult(8'd77, 8'd0, 1'b0, "q0");
        run_mult(8'd255, 8'd255, 1'b0, "max");
        run_mult(8'd200, 8'd128, 1'b1, "pulse");

        // Asynchronous reset in the middle of a SHIFT cycle.
        @(negedge clk);
        mcand  = 8'd9;
        mplier = 8'd7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!sh_en && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("midrst.in_shift", {31'd0, sh_en}, 32'd1);
        #2 rst = 1'b1;
        #1 check("midrst.outs", {25'd0, outs()}, 32'd0);
        @(negedge clk);
        check("midrst.held", {25'd0, outs()}, 32'd0);
        rst = 1'b0;
        run_mult(8'd9, 8'd7, 1'b0, "after_rst");

        for (int i = 0; i < 12; i++) begin
            run_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // Start held high: back-to-back products.
        @(negedge clk);
        mcand  = 8'd21;
        mplier = 8'd173;
        start  = 1'b1;
        @(negedge clk);
        d1 = 0;
        d2 = 0;
        init2 = 0;
        idle_cnt = 0;
        prod2 = '0;
        cyc = 1;
        while (cyc < 45) begin
            if (done && d1 == 0) d1 = cyc;
            else if (done && d2 == 0) begin
                d2 = cyc;
                prod2 = {a_r, q_r};
            end
            if (m_en && cyc > 1 && init2 == 0) init2 = cyc;
            if (d1 != 0 && init2 == 0 && !busy) idle_cnt++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("held.done1", d1, 2 * N + 2);
        check("held.init2", init2, 2 * N + 4);
        check("held.idle_cnt", idle_cnt, 1);
        check("held.done2", d2, 4 * N + 5);
        check("held.product2", {16'd0, prod2}, 21 * 173);
        guard = 0;
        while (busy && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("held.drain", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
